// File: rtl/apb_uart_regs_if.sv
// APB3 bus bundle between the CPU bus fabric and apb_uart_regs.
// The pslverr member exists only when APB_UART_PSLVERR_EN is defined.
interface apb_uart_regs_if;
  logic [3:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
`ifdef APB_UART_PSLVERR_EN
  logic        pslverr;
`endif

  // Handshake: an access completes on the rising edge where psel & penable are
  // both 1; pready is constant 1, so every access phase lasts exactly one cycle.
  modport master (
    output paddr, psel, penable, pwrite, pwdata,
`ifdef APB_UART_PSLVERR_EN
    input  pslverr,
`endif
    input  prdata, pready
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
`ifdef APB_UART_PSLVERR_EN
    output pslverr,
`endif
    output prdata, pready
  );
endinterface

// File: rtl/apb_uart_regs.sv
// APB3 register front-end for the uart core: TX/RX FIFOs, drain FSM, status/ctrl, irq.
// Optional macro APB_UART_PSLVERR_EN adds bus.pslverr for bad accesses.
module apb_uart_regs #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  apb_uart_regs_if.slave bus,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_done,
  input  logic [7:0]     rx_data,
  input  logic           rx_done,
  output logic           irq
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);

  typedef enum logic {S_IDLE, S_WAIT_DONE} drain_state_e;

  // Bus decode
  logic       access;
  logic [1:0] reg_sel;
  logic       wr_data_acc, rd_data_acc, wr_sts_acc, wr_ctrl_acc;

  assign access      = bus.psel & bus.penable;
  assign reg_sel     = bus.paddr[3:2];
  assign wr_data_acc = access &  bus.pwrite & (reg_sel == 2'd0);
  assign rd_data_acc = access & ~bus.pwrite & (reg_sel == 2'd0);
  assign wr_sts_acc  = access &  bus.pwrite & (reg_sel == 2'd1);
  assign wr_ctrl_acc = access &  bus.pwrite & (reg_sel == 2'd2);
  assign bus.pready  = 1'b1;

  // TX FIFO
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
  logic             tx_full, tx_empty, tx_push, tx_pop, tx_ovf_evt;

  assign tx_full    = (tx_cnt_q == TX_FULL_CNT);
  assign tx_empty   = (tx_cnt_q == '0);
  assign tx_push    = wr_data_acc & ~tx_full;
  assign tx_ovf_evt = wr_data_acc &  tx_full;

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(tx_push);
    tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(tx_pop);
    tx_cnt_d    = tx_cnt_q + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.pwdata[7:0];
  end

  // RX FIFO: a pop in the same cycle frees the slot, so a full FIFO still accepts rx_done
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
  logic             rx_full, rx_empty, rx_push, rx_pop, rx_ovr_evt;

  assign rx_full    = (rx_cnt_q == RX_FULL_CNT);
  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_pop     = rd_data_acc & ~rx_empty;
  assign rx_push    = rx_done & (~rx_full | rx_pop);
  assign rx_ovr_evt = rx_done & rx_full & ~rx_pop;

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(rx_push);
    rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(rx_pop);
    rx_cnt_d    = rx_cnt_q + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data;
  end

  // Drain FSM
  drain_state_e state_q, state_d;
  logic         tx_busy;
  logic         tx_start_q;
  logic [7:0]   tx_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!tx_empty) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_done)   state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = (state_q == S_IDLE) & ~tx_empty;
    tx_busy = (state_q == S_WAIT_DONE);
  end

  // Control and sticky status
  logic [1:0] ctrl_q, ctrl_d;
  logic       rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;

  always_comb begin
    ctrl_d   = ctrl_q;
    rx_ovr_d = rx_ovr_q;
    tx_ovf_d = tx_ovf_q;
    if (wr_ctrl_acc) ctrl_d = bus.pwdata[1:0];
    // A new error event in the clearing cycle wins so it is never lost
    if (wr_sts_acc && bus.pwdata[4]) rx_ovr_d = 1'b0;
    if (wr_sts_acc && bus.pwdata[6]) tx_ovf_d = 1'b0;
    if (rx_ovr_evt) rx_ovr_d = 1'b1;
    if (tx_ovf_evt) tx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      ctrl_q      <= 2'b00;
      rx_ovr_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_start_q  <= tx_pop;
      if (tx_pop) tx_data_q <= tx_mem_q[tx_rd_ptr_q];
      ctrl_q      <= ctrl_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_ovf_q    <= tx_ovf_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign irq      = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty & ~tx_busy);

  // Read mux
  logic [31:0] status;
  logic [31:0] prdata_c;

  assign status = {25'b0, tx_ovf_q, tx_busy, rx_ovr_q, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    prdata_c = 32'h0;
    if (access && !bus.pwrite) begin
      case (reg_sel)
        2'd0:    if (!rx_empty) prdata_c = {24'b0, rx_mem_q[rx_rd_ptr_q]};
        2'd1:    prdata_c = status;
        2'd2:    prdata_c = {30'b0, ctrl_q};
        default: prdata_c = 32'h0;
      endcase
    end
  end

  assign bus.prdata = prdata_c;

  // Error response
  logic slv_err;
  assign slv_err = access & ((reg_sel == 2'd3) | (wr_data_acc & tx_full) | (rd_data_acc & rx_empty));

`ifdef APB_UART_PSLVERR_EN
  assign bus.pslverr = slv_err;
`else
  logic unused_slv_err;
  assign unused_slv_err = slv_err;
`endif

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.paddr[1:0], bus.pwdata[31:8]};
endmodule

// File: tb/tb_apb_uart_regs.sv
// Self-checking bench for apb_uart_regs: register table, TX/RX scoreboards, FIFO corner cases.
module tb_apb_uart_regs;
  logic       clk;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       irq;

  apb_uart_regs_if bus ();

  apb_uart_regs #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .irq      (irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int checks   = 0;
  int failures = 0;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  bit   tx_hold  = 1'b0;
  int   tx_delay = 20;
  logic last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%08h exp=0x%08h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic apb_xfer(input logic [3:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd);
    @(negedge clk);
    bus.paddr = a; bus.pwrite = w; bus.pwdata = d; bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    #1;
    rd = bus.prdata;
`ifdef APB_UART_PSLVERR_EN
    last_err = bus.pslverr;
`else
    last_err = 1'b0;
`endif
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    apb_xfer(a, 1'b1, d, unused_rd);
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    apb_xfer(a, 1'b0, 32'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic rd_data_sb(input string name);
    logic [31:0] rd;
    logic [31:0] exp;
    exp = (rx_exp_q.size() > 0) ? {24'b0, rx_exp_q.pop_front()} : 32'h0;
    apb_xfer(4'h0, 1'b0, 32'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic rx_push(input logic [7:0] b, input bit expect_kept);
    @(negedge clk);
    rx_data = b; rx_done = 1'b1;
    if (expect_kept) rx_exp_q.push_back(b);
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // DATA read whose access cycle coincides with an rx_done pulse
  task automatic rx_read_with_push(input logic [7:0] b, output logic [31:0] rd);
    @(negedge clk);
    bus.paddr = 4'h0; bus.pwrite = 1'b0; bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1; rx_data = b; rx_done = 1'b1;
    #1;
    rd = bus.prdata;
`ifdef APB_UART_PSLVERR_EN
    last_err = bus.pslverr;
`else
    last_err = 1'b0;
`endif
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; rx_done = 1'b0;
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while (tx_exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tx_drain", 32'(tx_exp_q.size()), 32'h0);
  endtask

  // TX monitor: every tx_start is one cycle wide and carries the next expected byte
  initial begin : tx_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        check("tx_start_width", {31'b0, prev}, 32'h0);
        check("tx_start_expected", {31'b0, tx_exp_q.size() > 0}, 32'h1);
        if (tx_exp_q.size() > 0) check("tx_data", {24'b0, tx_data}, {24'b0, tx_exp_q.pop_front()});
      end
      prev = tx_start;
    end
  end

  // Transmitter model: tx_done tx_delay cycles after each start, withheld while tx_hold
  initial begin : tx_responder
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat (tx_delay) @(negedge clk);
        while (tx_hold) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  typedef struct {
    logic [3:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic        exp_err;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;

    vecs[0] = '{4'h4, 1'b0, 32'h0,        32'h0000_000A, 1'b0, 1'b0};
    vecs[1] = '{4'h8, 1'b0, 32'h0,        32'h0,         1'b0, 1'b0};
    vecs[2] = '{4'hC, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1};
    vecs[3] = '{4'h8, 1'b1, 32'hFFFF_FFFF, 32'h0,        1'b1, 1'b0};
    vecs[4] = '{4'h8, 1'b0, 32'h0,        32'h0000_0003, 1'b1, 1'b0};
    vecs[5] = '{4'hC, 1'b1, 32'h1234_5678, 32'h0,        1'b1, 1'b1};
    vecs[6] = '{4'hC, 1'b0, 32'h0,        32'h0,         1'b1, 1'b1};
    vecs[7] = '{4'h8, 1'b1, 32'h0,        32'h0,         1'b0, 1'b0};
    vecs[8] = '{4'h0, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1};
    vecs[9] = '{4'h4, 1'b0, 32'h0,        32'h0000_000A, 1'b0, 1'b0};

    reset = 1'b0;
    bus.paddr = 4'h0; bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.pwdata = 32'h0;
    rx_data = 8'h00; rx_done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_prdata", bus.prdata, 32'h0);
    check("rst_tx_start", {31'b0, tx_start}, 32'h0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Setup phase only: no read data, no error
    @(negedge clk);
    bus.paddr = 4'h4; bus.pwrite = 1'b0; bus.psel = 1'b1; bus.penable = 1'b0;
    #1;
    check("setup_prdata", bus.prdata, 32'h0);
    check("pready", {31'b0, bus.pready}, 32'h1);
`ifdef APB_UART_PSLVERR_EN
    check("setup_pslverr", {31'b0, bus.pslverr}, 32'h0);
`endif
    @(negedge clk);
    bus.psel = 1'b0;

    // Register table
    for (int i = 0; i < NV; i++) begin
      apb_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
`ifdef APB_UART_PSLVERR_EN
      check($sformatf("vec%0d_pslverr", i), {31'b0, last_err}, {31'b0, vecs[i].exp_err});
`endif
    end

    // Single byte transmit
    tx_delay = 20;
    tx_exp_q.push_back(8'h55);
    apb_wr(4'h0, 32'h0000_0055);
    rd_check("single_busy_status", 4'h4, 32'h0000_002A);
    wait_tx_drain(50);
    repeat (30) @(negedge clk);
    rd_check("single_done_status", 4'h4, 32'h0000_000A);

    // Fill TX with drain stalled, then overflow
    tx_hold = 1'b1;
    tx_delay = 2;
    for (int i = 1; i <= 9; i++) begin
      tx_exp_q.push_back(8'(i));
      apb_wr(4'h0, 32'(i));
    end
    rd_check("tx_full_status", 4'h4, 32'h0000_0029);
    apb_wr(4'h0, 32'h0000_000A);
`ifdef APB_UART_PSLVERR_EN
    check("tx_ovf_pslverr", {31'b0, last_err}, 32'h1);
`endif
    rd_check("tx_ovf_status", 4'h4, 32'h0000_0069);
    apb_wr(4'h4, 32'h0000_0040);
    rd_check("tx_ovf_clear", 4'h4, 32'h0000_0029);
    tx_hold = 1'b0;
    wait_tx_drain(400);
    repeat (10) @(negedge clk);
    rd_check("tx_drained_status", 4'h4, 32'h0000_000A);

    // Reset mid-transfer discards everything; late tx_done is ignored
    tx_hold = 1'b1;
    apb_wr(4'h8, 32'h0000_0002);
    tx_exp_q.push_back(8'hC1);
    apb_wr(4'h0, 32'h0000_00C1);
    apb_wr(4'h0, 32'h0000_00C2);
    apb_wr(4'h0, 32'h0000_00C3);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_tx_start", {31'b0, tx_start}, 32'h0);
    check("midrst_tx_data", {24'b0, tx_data}, 32'h0);
    tx_exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    tx_hold = 1'b0;
    repeat (10) @(negedge clk);
    rd_check("midrst_status", 4'h4, 32'h0000_000A);
    rd_check("midrst_ctrl", 4'h8, 32'h0);

    // RX basic ordering and empty read
    rx_push(8'hA5, 1'b1);
    rx_push(8'h3C, 1'b1);
    rd_data_sb("rx_read0");
    rd_data_sb("rx_read1");
    rd_data_sb("rx_read_empty");
    rd_check("rx_empty_status", 4'h4, 32'h0000_000A);

    // RX overrun
    for (int i = 0; i < 8; i++) rx_push(8'($urandom_range(0, 255)), 1'b1);
    rx_push(8'hFF, 1'b0);
    rd_check("rx_ovr_status", 4'h4, 32'h0000_0016);
    for (int i = 0; i < 8; i++) rd_data_sb($sformatf("rx_ovr_read%0d", i));
    rd_check("rx_ovr_sticky", 4'h4, 32'h0000_001A);
    apb_wr(4'h4, 32'h0000_0010);
    rd_check("rx_ovr_clear", 4'h4, 32'h0000_000A);

    // Full RX: push and pop in the same cycle
    for (int i = 0; i < 8; i++) rx_push(8'($urandom_range(0, 255)), 1'b1);
    rx_read_with_push(8'h77, rd);
    check("rx_full_pushpop_rd", rd, {24'b0, rx_exp_q.pop_front()});
    rx_exp_q.push_back(8'h77);
    rd_check("rx_full_pushpop_status", 4'h4, 32'h0000_0006);
    for (int i = 0; i < 8; i++) rd_data_sb($sformatf("rx_pp_read%0d", i));
    rd_check("rx_pp_drained", 4'h4, 32'h0000_000A);

    // Empty RX: push wins, read returns 0
    rx_read_with_push(8'h5A, rd);
    check("rx_empty_pushpop_rd", rd, 32'h0);
`ifdef APB_UART_PSLVERR_EN
    check("rx_empty_pslverr", {31'b0, last_err}, 32'h1);
`endif
    rx_exp_q.push_back(8'h5A);
    rd_check("rx_empty_pushpop_status", 4'h4, 32'h0000_0002);
    rd_data_sb("rx_empty_pushpop_read");

    // Interrupts
    apb_wr(4'h8, 32'h0000_0001);
    check("irq_rx_none", {31'b0, irq}, 32'h0);
    rx_push(8'h11, 1'b1);
    check("irq_rx_set", {31'b0, irq}, 32'h1);
    rd_data_sb("irq_rx_read");
    check("irq_rx_clear", {31'b0, irq}, 32'h0);
    apb_wr(4'h8, 32'h0000_0002);
    check("irq_tx_set", {31'b0, irq}, 32'h1);
    apb_wr(4'h8, 32'h0000_0000);
    check("irq_off", {31'b0, irq}, 32'h0);

    repeat (5) @(negedge clk);
    check("tx_sb_empty", 32'(tx_exp_q.size()), 32'h0);
    check("rx_sb_empty", 32'(rx_exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
